// File: rtl/cpu_phase_ctrl.sv
// Single-clock instruction-phase sequencer: one-hot phases, (cfg_div+1) cycles per phase, FETCH/MEM stall on mem_ready.
// CPU_PHASE_PERF_EN adds cycle/instruction/stall counters; without it those ports tie to 0.
module cpu_phase_ctrl #(
    parameter int DIV_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             run,
    input  logic             step,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             mem_ready,
    input  logic             is_mem_op,
    input  logic             halt_req,
    output logic [4:0]       phase,
    output logic             adv,
    output logic             mem_req,
    output logic             pc_en,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    // Encoding is the phase vector itself, so phase is a direct register copy.
    typedef enum logic [4:0] {
        S_IDLE   = 5'b00000,
        S_FETCH  = 5'b00001,
        S_DECODE = 5'b00010,
        S_EXEC   = 5'b00100,
        S_MEM    = 5'b01000,
        S_WB     = 5'b10000
    } state_t;

    localparam logic [DIV_W-1:0] P_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_l;
    logic [DIV_W-1:0] pcnt;
    logic             step_l, memop_l, halt_l, halted_r;
    logic             tick, mem_phase;

    always_comb begin
        tick      = (pcnt == div_l);
        mem_phase = (state == S_FETCH) || (state == S_MEM);
        adv       = (state != S_IDLE) && tick && (mem_ready || !mem_phase);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (step || (run && !halted_r)) state_nxt = S_FETCH;
            S_FETCH:  if (adv) state_nxt = S_DECODE;
            S_DECODE: if (adv) state_nxt = S_EXEC;
            S_EXEC:   if (adv) state_nxt = memop_l ? S_MEM : S_WB;
            S_MEM:    if (adv) state_nxt = S_WB;
            S_WB: begin
                if (adv) begin
                    if (halt_l || step_l || !run) state_nxt = S_IDLE;
                    else                          state_nxt = S_FETCH;
                end
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            pcnt     <= '0;
            div_l    <= '0;
            step_l   <= 1'b0;
            memop_l  <= 1'b0;
            halt_l   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                pcnt <= '0;
            else if (pcnt < div_l)
                pcnt <= pcnt + P_ONE;

            // New pacing only at instruction boundaries.
            if (state_nxt == S_FETCH && state != S_FETCH)
                div_l <= cfg_div;

            if (state == S_IDLE && step) begin
                step_l   <= 1'b1;
                halted_r <= 1'b0;
            end

            if (state == S_DECODE && adv) begin
                memop_l <= is_mem_op;
                halt_l  <= halt_req;
            end

            if (state == S_WB && adv) begin
                step_l  <= 1'b0;
                memop_l <= 1'b0;
                halt_l  <= 1'b0;
                if (halt_l) halted_r <= 1'b1;
            end
        end
    end

    assign phase   = state;
    assign busy    = (state != S_IDLE);
    assign mem_req = mem_phase;
    assign pc_en   = adv && (state == S_WB);
    assign halted  = halted_r;

`ifdef CPU_PHASE_PERF_EN
    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cyc_r, instr_r, stall_r;
    logic             stall;

    assign stall = mem_phase && tick && !mem_ready;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cyc_r   <= '0;
            instr_r <= '0;
            stall_r <= '0;
        end else begin
            if (busy)  cyc_r   <= cyc_r + C_ONE;
            if (pc_en) instr_r <= instr_r + C_ONE;
            if (stall) stall_r <= stall_r + C_ONE;
        end
    end

    assign cyc_cnt   = cyc_r;
    assign instr_cnt = instr_r;
    assign stall_cnt = stall_r;
`else
    assign cyc_cnt   = '0;
    assign instr_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Randomized + scenario bench for cpu_phase_ctrl with a per-cycle expected-output scoreboard.
module tb_cpu_phase_ctrl;

    logic        sys_clk, sys_rst, run, step, mem_ready, is_mem_op, halt_req;
    logic [3:0]  cfg_div;
    logic [4:0]  phase;
    logic        adv, mem_req, pc_en, busy, halted;
    logic [31:0] cyc_cnt, instr_cnt, stall_cnt;

    cpu_phase_ctrl #(.DIV_W(4), .CNT_W(32)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .run(run), .step(step),
        .cfg_div(cfg_div), .mem_ready(mem_ready), .is_mem_op(is_mem_op),
        .halt_req(halt_req), .phase(phase), .adv(adv), .mem_req(mem_req),
        .pc_en(pc_en), .busy(busy), .halted(halted), .cyc_cnt(cyc_cnt),
        .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [4:0]  phase;
        logic        adv, mem_req, pc_en, busy, halted;
        logic [31:0] cyc, ins, stl;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk = 0;

    // Reference model: phase index 0..4 = F,D,E,M,W and cycles spent in the phase.
    bit          m_busy, m_mem, m_halt, m_step, m_halted;
    int          m_ph, m_age, m_div, m_ret;
    logic [31:0] m_cyc, m_ins, m_stl;

    initial sys_clk = 0;
    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (q.size() > 0) begin
            exp_t e, a;
            e = q.pop_front();
            a = {phase, adv, mem_req, pc_en, busy, halted, cyc_cnt, instr_cnt, stall_cnt};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL vec%0d outputs: got ph=%b adv=%b mreq=%b pc=%b busy=%b hlt=%b cnt=%0d/%0d/%0d, want ph=%b adv=%b mreq=%b pc=%b busy=%b hlt=%b cnt=%0d/%0d/%0d",
                         vectors, a.phase, a.adv, a.mem_req, a.pc_en, a.busy, a.halted, a.cyc, a.ins, a.stl,
                         e.phase, e.adv, e.mem_req, e.pc_en, e.busy, e.halted, e.cyc, e.ins, e.stl);
            end
        end
    end

    task automatic model_reset();
        m_busy = 0; m_mem = 0; m_halt = 0; m_step = 0; m_halted = 0;
        m_ph = 0; m_age = 0; m_div = 0;
        m_cyc = 0; m_ins = 0; m_stl = 0;
    endtask

    // Drive one cycle of inputs, predict this cycle's outputs, advance the model, step the clock.
    task automatic cyc(input bit r, input bit st, input bit rn, input int dv,
                       input bit mr, input bit mo, input bit hr);
        exp_t e;
        bit   tick, memph, a;
        sys_rst = r; step = st; run = rn; cfg_div = 4'(dv);
        mem_ready = mr; is_mem_op = mo; halt_req = hr;

        tick  = (m_age >= m_div);
        memph = m_busy && (m_ph == 0 || m_ph == 3);
        a     = m_busy && tick && (mr || !memph);
        e.phase   = m_busy ? 5'(1 << m_ph) : 5'd0;
        e.adv     = a;
        e.mem_req = memph;
        e.pc_en   = a && (m_ph == 4);
        e.busy    = m_busy;
        e.halted  = m_halted;
`ifdef CPU_PHASE_PERF_EN
        e.cyc = m_cyc; e.ins = m_ins; e.stl = m_stl;
`else
        e.cyc = '0; e.ins = '0; e.stl = '0;
`endif
        if (chk) q.push_back(e);

        if (r) begin
            model_reset();
        end else begin
            if (m_busy) m_cyc++;
            if (e.pc_en) begin m_ins++; m_ret++; end
            if (memph && tick && !mr) m_stl++;
            if (!m_busy) begin
                if (st || (rn && !m_halted)) begin
                    m_busy = 1; m_ph = 0; m_age = 0; m_div = dv;
                    m_step = st;
                    if (st) m_halted = 0;
                end
            end else if (a) begin
                m_age = 0;
                case (m_ph)
                    0: m_ph = 1;
                    1: begin m_ph = 2; m_mem = mo; m_halt = hr; end
                    2: m_ph = m_mem ? 3 : 4;
                    3: m_ph = 4;
                    default: begin
                        if (m_halt) begin m_busy = 0; m_halted = 1; end
                        else if (m_step || !rn) m_busy = 0;
                        else begin m_ph = 0; m_div = dv; end
                        m_mem = 0; m_halt = 0; m_step = 0;
                    end
                endcase
            end else if (m_age < 64) begin
                m_age++;
            end
        end
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        model_reset();
        m_ret = 0;
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk = 1;
        cyc(1, 0, 0, 0, 1, 0, 0);

        // Free-run, single-cycle phases.
        repeat (12) cyc(0, 0, 1, 0, 1, 0, 0);
        repeat (6)  cyc(0, 0, 0, 0, 1, 0, 0);

        // Single step of a memory op with 3-cycle phases.
        cyc(0, 1, 0, 2, 1, 1, 0);
        repeat (18) cyc(0, 0, 0, 2, 1, 1, 0);

        // FETCH stalled three cycles on mem_ready.
        cyc(0, 1, 0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        repeat (6) cyc(0, 0, 0, 0, 1, 0, 0);

        // Halt on second instruction, run held high, then single step.
        m_ret = 0;
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 1, 0, m_ret == 1);
        repeat (4) cyc(0, 0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 0);
        repeat (8) cyc(0, 0, 0, 0, 1, 0, 0);

        // Reset asserted during MEM, then run restarts.
        cyc(0, 1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 20 && !(m_busy && m_ph == 3); i++) cyc(0, 0, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 1, 1, 0);
        repeat (4) cyc(0, 0, 1, 0, 1, 0, 0);
        repeat (6) cyc(0, 0, 0, 0, 1, 0, 0);

        // Step while busy ignored; divider change applies to the next instruction.
        cyc(0, 0, 1, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1, 0, 0);
        cyc(0, 0, 1, 3, 1, 0, 0);
        cyc(0, 1, 1, 3, 1, 0, 0);
        repeat (20) cyc(0, 0, 1, 3, 1, 0, 0);
        repeat (20) cyc(0, 0, 0, 3, 1, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 9) < 8,
                int'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 15) == 0);
        end

        repeat (3) @(posedge sys_clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
